interval_timer_ctrl: RTL and testbench

//  Programmable interval timer controller that owns and sequences a WIDTH-bit up-count register.

---
 rtl/interval_timer_pkg.sv | 14 +
 rtl/interval_timer_ctrl_prescaler.sv | 28 ++
 rtl/interval_timer_ctrl.sv | 155 +++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared state encoding and default sizes for the interval timer
package interval_timer_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_PRESCALE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/interval_timer_ctrl_prescaler.sv
// rtl/interval_timer_ctrl_prescaler.sv - tick divider: one tick every div+1 clocks while not cleared
module timer_prescaler
    import interval_timer_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt;

    assign tick = (presc_cnt == div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - interval timer FSM, up-count register, terminal compare and done flag
// Optional count capture register enabled by defining CAPTURE_EN.
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_periodic,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  done_clr,
`ifdef CAPTURE_EN
    input  logic                  capture,
    output logic [WIDTH-1:0]      cap_count,
    output logic                  cap_valid,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tc_pulse,
    output logic                  done
);

    timer_state_e          state;
    logic [WIDTH-1:0]      period_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  periodic_q;

    logic cfg_fire;
    logic go;
    logic tick;
    logic at_tick;
    logic at_tc;
    logic presc_clear;

    assign cfg_ready = (state != RUN);
    assign cfg_fire  = cfg_valid & cfg_ready;

    // stop always wins over start; a surviving start also pre-empts any tick
    assign go      = start & ~stop;
    assign at_tick = (state == RUN) & ~stop & ~start & tick;
    assign at_tc   = at_tick & (count == period_q);

    // hold the divider at zero outside RUN so every run starts on a full prescale period
    assign presc_clear = (state != RUN) | start | stop | (at_tc & ~periodic_q);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .div   (prescale_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            busy       <= 1'b0;
            tc_pulse   <= 1'b0;
            done       <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;

            if (cfg_fire) begin
                period_q   <= cfg_period;
                prescale_q <= cfg_prescale;
                periodic_q <= cfg_periodic;
            end

            if (at_tc && !periodic_q) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (go) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= ARMED;
                        busy  <= 1'b0;
                    end else if (start) begin
                        count <= '0;
                    end else if (at_tc) begin
                        tc_pulse <= 1'b1;
                        if (periodic_q) begin
                            count <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end else if (at_tick) begin
                        count <= count + WIDTH'(1);
                    end
                end
                DONE: begin
                    if (go) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end else if (cfg_fire) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_EN
    logic start_run;

    assign start_run = go & (state != IDLE);

    // capture takes the pre-update count, so it sees the value visible this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_count <= '0;
            cap_valid <= 1'b0;
        end else if (capture) begin
            cap_count <= count;
            cap_valid <= 1'b1;
        end else if (start_run) begin
            cap_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - scoreboard bench for interval_timer_ctrl (capture checks when CAPTURE_EN is defined)
module tb_interval_timer_ctrl;

    localparam int WIDTH      = 32;
    localparam int PRESCALE_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_period;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_periodic;
    logic                  start;
    logic                  stop;
    logic                  done_clr;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc_pulse;
    logic                  done;
`ifdef CAPTURE_EN
    logic                  capture;
    logic [WIDTH-1:0]      cap_count;
    logic                  cap_valid;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] cnt;
        logic        bsy;
        logic        tc;
        logic        dn;
        logic        rdy;
        logic        capv;
        logic [31:0] capc;
    } exp_t;

    exp_t        sb[$];
    int          cyc     = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    logic        exp_capv = 1'b0;
    logic [31:0] exp_capc = '0;
    int          seq[12] = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};

    interval_timer_ctrl #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .done_clr     (done_clr),
`ifdef CAPTURE_EN
        .capture      (capture),
        .cap_count    (cap_count),
        .cap_valid    (cap_valid),
`endif
        .count        (count),
        .busy         (busy),
        .tc_pulse     (tc_pulse),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, want);
    endtask

    // expectation for the outputs seen after the coming clock edge
    task automatic expect_next(string nm, int c, bit b, bit tc, bit d, bit r);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.cnt  = c;
        e.bsy  = b;
        e.tc   = tc;
        e.dn   = d;
        e.rdy  = r;
        e.capv = exp_capv;
        e.capc = exp_capc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        start     = 1'b0;
        stop      = 1'b0;
        done_clr  = 1'b0;
        cfg_valid = 1'b0;
`ifdef CAPTURE_EN
        capture   = 1'b0;
`endif
    endtask

    // monitor: compare whatever expectations fall due at this sample point
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, ".late"}, cyc, e.cyc);
            end else begin
                chk({e.name, ".count"}, count, e.cnt);
                chk({e.name, ".busy"}, {31'd0, busy}, {31'd0, e.bsy});
                chk({e.name, ".tc_pulse"}, {31'd0, tc_pulse}, {31'd0, e.tc});
                chk({e.name, ".done"}, {31'd0, done}, {31'd0, e.dn});
                chk({e.name, ".cfg_ready"}, {31'd0, cfg_ready}, {31'd0, e.rdy});
`ifdef CAPTURE_EN
                chk({e.name, ".cap_valid"}, {31'd0, cap_valid}, {31'd0, e.capv});
                if (e.capv) chk({e.name, ".cap_count"}, cap_count, e.capc);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_period   = '0;
        cfg_prescale = '0;
        cfg_periodic = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        done_clr     = 1'b0;
`ifdef CAPTURE_EN
        capture      = 1'b0;
`endif
        expect_next("reset", 0, 0, 0, 0, 1);
        step();
        reset = 1'b0;

        // one-shot P=3, prescale 0
        cfg_valid = 1'b1; cfg_period = 3; cfg_prescale = 0; cfg_periodic = 1'b0;
        expect_next("t1_load", 0, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t1_start", 0, 1, 0, 0, 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            expect_next("t1_count", i, 1, 0, 0, 0);
            step();
        end
        expect_next("t1_tc", 3, 0, 1, 1, 1);
        step();
        expect_next("t1_hold", 3, 0, 0, 1, 1);
        step();

        // done set beats same-cycle done_clr
        done_clr = 1'b1;
        expect_next("t4_clr", 3, 0, 0, 0, 1);
        step();
        cfg_valid = 1'b1; cfg_period = 1; cfg_prescale = 0; cfg_periodic = 1'b0;
        expect_next("t4_load", 3, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t4_start", 0, 1, 0, 0, 0);
        step();
        expect_next("t4_count", 1, 1, 0, 0, 0);
        step();
        done_clr = 1'b1;
        expect_next("t4_set_beats_clr", 1, 0, 1, 1, 1);
        step();
        done_clr = 1'b1;
        expect_next("t4_clr_next", 1, 0, 0, 0, 1);
        step();

        // periodic P=2, prescale 1; a load attempt in RUN must be refused
        cfg_valid = 1'b1; cfg_period = 2; cfg_prescale = 1; cfg_periodic = 1'b1;
        expect_next("t2_load", 1, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t2_start", 0, 1, 0, 0, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                cfg_valid = 1'b1; cfg_period = 9; cfg_prescale = 0; cfg_periodic = 1'b0;
            end
            expect_next((i >= 6) ? "t5_cfg_in_run" : "t2_periodic", seq[i], 1,
                        (i == 5 || i == 11), 0, 0);
            step();
        end

        // stop beats start
        stop = 1'b1;
        expect_next("t3_stop", 0, 0, 0, 0, 1);
        step();
        cfg_valid = 1'b1; cfg_period = 10; cfg_prescale = 0; cfg_periodic = 1'b0;
        expect_next("t3_load", 0, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t3_start", 0, 1, 0, 0, 0);
        step();
        for (int i = 1; i <= 5; i++) begin
            expect_next("t3_run", i, 1, 0, 0, 0);
            step();
        end
        start = 1'b1; stop = 1'b1;
        expect_next("t3_stop_beats_start", 5, 0, 0, 0, 1);
        step();
        expect_next("t3_armed_hold", 5, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t3_restart", 0, 1, 0, 0, 0);
        step();

        // capture at count 7, then restart in RUN
        for (int i = 1; i <= 10; i++) begin
`ifdef CAPTURE_EN
            if (i - 1 == 7) begin
                capture  = 1'b1;
                exp_capv = 1'b1;
                exp_capc = 7;
            end
`endif
            expect_next("t6_run", i, 1, 0, 0, 0);
            step();
        end
        start = 1'b1;
`ifdef CAPTURE_EN
        exp_capv = 1'b0;
`endif
        expect_next("t6_restart", 0, 1, 0, 0, 0);
        step();

        // reset on the cycle a terminal tick would fire
        for (int i = 1; i <= 10; i++) begin
            expect_next("t5_run", i, 1, 0, 0, 0);
            step();
        end
        reset = 1'b1;
        expect_next("t5_reset", 0, 0, 0, 0, 1);
        step();
        reset = 1'b0;
        expect_next("t5_after_reset", 0, 0, 0, 0, 1);
        step();
        start = 1'b1;
        expect_next("t5_idle_start_ignored", 0, 0, 0, 0, 1);
        step();
        step();
        step();

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
